// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit: PC, single-outstanding memory requests, instruction buffer.
// Optional halt-on-8'hFF behaviour is enabled by defining FETCH_HALT_EN.
module instr_fetch #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fetch_en,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    output logic       ins_valid,
    output logic [7:0] ins_data,
    input  logic       ins_ready,
    input  logic       jmp_valid,
    input  logic [7:0] jmp_addr,
    output logic       halted
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP,
        HALT
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      pc_q, pc_d;
    logic            mem_req_q, mem_req_d;
    logic [7:0]      mem_addr_q, mem_addr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      buf_q [DEPTH];
    logic            push;
    logic            pop;
    logic            flush;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        push       = 1'b0;
        flush      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (jmp_valid) begin
                    pc_d  = jmp_addr;
                    flush = 1'b1;
                end else if (fetch_en && (count_q < FULL)) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_q;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (jmp_valid) begin
                    pc_d  = jmp_addr;
                    flush = 1'b1;
                    if (mem_ack) begin
                        mem_req_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        state_d = DROP;
                    end
                end else if (mem_ack) begin
                    push      = 1'b1;
                    pc_d      = pc_q + 8'd1;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
`ifdef FETCH_HALT_EN
                    if (mem_rdata == 8'hFF) begin
                        state_d = HALT;
                    end
`endif
                end
            end
            DROP: begin
                // The in-flight byte belongs to the abandoned stream; wait it out.
                if (jmp_valid) begin
                    pc_d  = jmp_addr;
                    flush = 1'b1;
                end
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            HALT: begin
                if (jmp_valid) begin
                    pc_d    = jmp_addr;
                    flush   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ins_valid = (count_q != '0);
    assign ins_data  = ins_valid ? buf_q[rd_ptr_q] : 8'h00;
    assign pop       = ins_valid && ins_ready && !flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= 8'h00;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 8'h00;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: count_q gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wr_ptr_q] <= mem_rdata;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

`ifdef FETCH_HALT_EN
    assign halted = (state_q == HALT);
`else
    assign halted = 1'b0;
`endif

endmodule
